execute_unit: RTL and testbench
===============================

# execute_unit

Integer execute stage of the RISCAT core. Accepts one decoded operation per handshake, computes the RV32I ALU result (and, optionally, RV32M multiply results through an iterative multiplier), and presents it to the writeback stage as a one-cycle result_ready pulse with alu_result and wr_addr. It sits directly between decode and writeback.

## Interface

Parameters:
- MUL_STEP_BITS, 1, multiplier bits retired per iteration; legal values 1, 2, 4; multiply latency L = 32 / MUL_STEP_BITS.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- op_valid  in  1  decode presents an operation
- op_ready  out  1  stage can accept; transfer on op_valid && op_ready at posedge
- op_code  in  5  alu_op_t
- op_a  in  32  operand A (rs1)
- op_b  in  32  operand B (rs2 or immediate)
- op_rd  in  5  destination register
- result_ready  out  1  one-cycle pulse: result valid
- alu_result  out  32  result
- wr_addr  out  5  destination register of the result
- busy  out  1  multiply in progress

## Operation

- FSM states: IDLE, BUSY. op_ready = (state == IDLE); busy = (state == BUSY).
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount op_b[4:0]), SLT (signed), SLTU (unsigned; result 0 or 1), PASS_B (LUI).
- Multiply ops: MUL (low 32 bits), MULH (s×s high), MULHSU (s×u high), MULHU (u×u high). Arithmetic: take magnitudes of the signed operands, form the 64-bit unsigned product iteratively, then negate the 64-bit product if exactly one signed operand was negative; select the low or high word.
- Unknown op_code: result 0x00000000, single-cycle, pulse still issued.
- rd = 0: result still issued with wr_addr = 0; discarding it is the register file's job.
- All arithmetic mod 2^32; no overflow flags.
- alu_result and wr_addr are registered and hold their last value while result_ready is low.
- Reset mid-operation: multiply aborted, no result pulse, state → IDLE.

## Timing

- Reset values: result_ready 0, alu_result 0, wr_addr 0, busy 0, op_ready 1.
- Single-cycle op accepted at edge N: result_ready = 1 with result from edge N until edge N+1. Back-to-back accepts every cycle are permitted.
- Multiply accepted at edge N: state goes BUSY at N, and op_ready is low from N. Iterations occur at edges N+1 … N+L-1. The result is registered at edge N+L, so result_ready is high for one cycle after N+L. The state returns to IDLE at the same edge, so a new op may be accepted at edge N+L+1.
- op_valid while BUSY is not accepted. Inputs may change freely until accepted; operands are captured at acceptance.

## Configuration

- EXEC_MUL_EN defined: multiplier and BUSY state built as above.
- Not defined: no multiplier instance. MUL* codes behave as unknown ops (result 0, single cycle). op_ready is tied to 1 and busy to 0. MUL_STEP_BITS is ignored.

## Structure

- riscat_pkg holds alu_op_t (5-bit enum) and XLEN = 32.
- Encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASS_B 10, MUL 16, MULH 17, MULHSU 18, MULHU 19.
- Sub-module mul_iter: iterative shift-add unsigned 32×32→64 with start/done handshake, parameterised by MUL_STEP_BITS. Instantiated only under EXEC_MUL_EN. Sign handling stays in execute_unit.

## Test plan

- ADD op_a=5, op_b=7, rd=3 -> next cycle result_ready=1, alu_result=12, wr_addr=3; result_ready=0 the following cycle.
- Back-to-back ops on consecutive cycles:
  - SRA 0x80000000 by 4 -> 0xF8000000
  - SLT 0xFFFFFFFF, 1 -> 1
  - SLTU 0xFFFFFFFF, 1 -> 0
  - Expect three consecutive pulses with matching wr_addr.
- MUL_STEP_BITS=1, op_a=0xFFFFFFFF, op_b=3:
  - MUL -> 0xFFFFFFFD
  - MULH -> 0xFFFFFFFF
  - MULHU -> 0x00000002
  - MULHSU -> 0xFFFFFFFF
  - For each: pulse 32 cycles after accept; op_ready low throughout.
- ADD held on op_valid during a multiply -> accepted only at the first edge with op_ready=1; exactly two result pulses, multiply result first.
- reset_n asserted 10 cycles into a MUL -> all outputs at reset values, no result pulse; after release op_ready=1 and a new ADD completes normally.
- Build without EXEC_MUL_EN: MUL 6×7 rd=5 -> next cycle result_ready=1, alu_result=0, wr_addr=5; op_ready never drops.

Source files
------------

// File: rtl/riscat_pkg.sv
// Shared definitions for the RISCAT integer datapath: operation encodings
// and the machine word width.
package riscat_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_PASS_B = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19
  } alu_op_t;

  // True for the RV32M multiply family, which takes the iterative path.
  function automatic logic is_mul_op(input logic [4:0] code);
    return (code == OP_MUL) || (code == OP_MULH) ||
           (code == OP_MULHSU) || (code == OP_MULHU);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add unsigned 32x32 -> 64 multiplier. start loads the
// operands; MUL_STEP_BITS multiplier bits are retired per clock. done is
// high during the final iteration cycle, when product already shows the
// complete result, so the caller can register it on that same edge.
module mul_iter #(
  parameter int MUL_STEP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] product
);

  localparam int STEPS = 32 / MUL_STEP_BITS;

  logic        active_q, active_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] partial;
  logic [63:0] acc_next;

  // One shift-add step per cycle; load fresh operands on start.
  always_comb begin
    partial  = mcand_q * {{(64-MUL_STEP_BITS){1'b0}}, mplier_q[MUL_STEP_BITS-1:0]};
    acc_next = acc_q + partial;
    product  = acc_next;
    done     = active_q && (cnt_q == 6'(STEPS - 1));
    active_d = active_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = 6'd0;
      mcand_d  = {32'd0, a};
      mplier_d = b;
      acc_d    = 64'd0;
    end else if (active_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << MUL_STEP_BITS;
      mplier_d = mplier_q >> MUL_STEP_BITS;
      cnt_d    = cnt_q + 6'd1;
      if (done) active_d = 1'b0;
    end
  end

  // Control state: cleared by reset so an aborted multiply never completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      cnt_q    <= 6'd0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  // Datapath registers: always reloaded on start, so no reset needed.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

endmodule

// File: rtl/execute_unit.sv
// RISCAT integer execute stage. Single-cycle RV32I ALU ops produce a
// registered result pulse the cycle after acceptance. With EXEC_MUL_EN
// defined, RV32M multiplies run through mul_iter and hold the stage BUSY;
// without it, multiply codes fall through as unknown ops (result 0).
module execute_unit
  import riscat_pkg::*;
#(
  parameter int MUL_STEP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [4:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  output logic        result_ready,
  output logic [31:0] alu_result,
  output logic [4:0]  wr_addr,
  output logic        busy
);

  if (!(MUL_STEP_BITS == 1 || MUL_STEP_BITS == 2 || MUL_STEP_BITS == 4)) begin : g_bad_step
    $error("execute_unit: MUL_STEP_BITS must be 1, 2 or 4");
  end

  // Single-cycle RV32I operations; anything unrecognised yields zero.
  function automatic logic [XLEN-1:0] alu_single(input alu_op_t op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SLL:    return a << b[4:0];
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    return sa >>> b[4:0];
      OP_SLT:    return {31'd0, sa < sb};
      OP_SLTU:   return {31'd0, a < b};
      OP_PASS_B: return b;
      default:   return '0;
    endcase
  endfunction

  logic        result_ready_q, result_ready_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] single_res;

  assign single_res   = alu_single(alu_op_t'(op_code), op_a, op_b);
  assign result_ready = result_ready_q;
  assign alu_result   = alu_result_q;
  assign wr_addr      = wr_addr_q;

`ifdef EXEC_MUL_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        neg_q, neg_d;
  logic        hi_q, hi_d;
  logic [4:0]  rd_q, rd_d;
  logic        mul_start;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        mul_done;
  logic [63:0] mul_product;
  logic [63:0] prod_signed;

  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_BUSY);

  mul_iter #(.MUL_STEP_BITS(MUL_STEP_BITS)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a_mag),
    .b       (b_mag),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next-state, sign pre/post processing and result selection.
  always_comb begin
    state_d        = state_q;
    neg_d          = neg_q;
    hi_d           = hi_q;
    rd_d           = rd_q;
    mul_start      = 1'b0;
    a_neg          = op_a[31] && ((op_code == OP_MULH) || (op_code == OP_MULHSU));
    b_neg          = op_b[31] && (op_code == OP_MULH);
    a_mag          = a_neg ? -op_a : op_a;
    b_mag          = b_neg ? -op_b : op_b;
    prod_signed    = neg_q ? -mul_product : mul_product;
    result_ready_d = 1'b0;
    alu_result_d   = alu_result_q;
    wr_addr_d      = wr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (is_mul_op(op_code)) begin
            mul_start = 1'b1;
            state_d   = ST_BUSY;
            neg_d     = a_neg ^ b_neg;
            hi_d      = (op_code != OP_MUL);
            rd_d      = op_rd;
          end else begin
            result_ready_d = 1'b1;
            alu_result_d   = single_res;
            wr_addr_d      = op_rd;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          result_ready_d = 1'b1;
          alu_result_d   = hi_q ? prod_signed[63:32] : prod_signed[31:0];
          wr_addr_d      = rd_q;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Multiply context captured at acceptance; consumed when the product lands.
  always_ff @(posedge clk) begin
    neg_q <= neg_d;
    hi_q  <= hi_d;
    rd_q  <= rd_d;
  end
`else
  assign op_ready = 1'b1;
  assign busy     = 1'b0;

  // Every accepted op completes in one cycle.
  always_comb begin
    result_ready_d = op_valid;
    alu_result_d   = alu_result_q;
    wr_addr_d      = wr_addr_q;
    if (op_valid) begin
      alu_result_d = single_res;
      wr_addr_d    = op_rd;
    end
  end
`endif

  // Writeback-facing result registers; values hold between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_ready_q <= 1'b0;
      alu_result_q   <= 32'd0;
      wr_addr_q      <= 5'd0;
    end else begin
      result_ready_q <= result_ready_d;
      alu_result_q   <= alu_result_d;
      wr_addr_q      <= wr_addr_d;
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Testbench for execute_unit. Directed steps plus randomized operations,
// checked against a behavioural model computed with plain 64-bit arithmetic.
// Multiply-specific steps are built when EXEC_MUL_EN is defined.
module tb_execute_unit;

  localparam logic [4:0] C_ADD = 5'd0, C_SRA = 5'd7, C_SLT = 5'd8, C_SLTU = 5'd9;
  localparam logic [4:0] C_MUL = 5'd16, C_MULH = 5'd17, C_MULHSU = 5'd18, C_MULHU = 5'd19;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_rd;
  logic        result_ready;
  logic [31:0] alu_result;
  logic [4:0]  wr_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_unit #(.MUL_STEP_BITS(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_rd        (op_rd),
    .result_ready (result_ready),
    .alu_result   (alu_result),
    .wr_addr      (wr_addr),
    .busy         (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: results from the arithmetic definitions of each op.
  function automatic logic [31:0] ref_result(input logic [4:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 0;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd10: return b;
`ifdef EXEC_MUL_EN
      5'd16: begin p = sa * sb; pb = p; return pb[31:0];  end
      5'd17: begin p = sa * sb; pb = p; return pb[63:32]; end
      5'd18: begin p = sa * ub; pb = p; return pb[63:32]; end
      5'd19: begin p = ua * ub; pb = p; return pb[63:32]; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    op_valid = v;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    op_rd    = rd;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},    32'(result_ready), 32'd0);
    chk({tag, "_result"},   alu_result,        32'd0);
    chk({tag, "_wr_addr"},  32'(wr_addr),      32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_op_ready"}, 32'(op_ready),     32'd1);
  endtask

`ifdef EXEC_MUL_EN
  // Issue one multiply, then watch latency, op_ready and the single pulse.
  task automatic run_mul(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    int lat;
    lat = -1;
    drive(1'b1, op, a, b, rd);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        op_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (result_ready === 1'b1) begin
        lat = k;
        break;
      end
      chk({tag, "_op_ready_low"}, 32'(op_ready), 32'd0);
    end
    chk({tag, "_latency"}, 32'(lat), 32'd32);
    chk({tag, "_result"},  alu_result, ref_result(op, a, b));
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(rd));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(result_ready), 32'd0);
    chk({tag, "_idle"},      32'(op_ready),     32'd1);
  endtask
`endif

  initial begin
    logic [31:0] corner [4];
    logic [31:0] last_res;
    logic [4:0]  last_rd;
    logic [4:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_rd;
    logic        r_v;
    int          pulses;

    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;

    // Reset values
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // ADD 5 + 7 -> rd 3, single pulse, held value
    drive(1'b1, C_ADD, 32'd5, 32'd7, 5'd3);
    @(negedge clk);
    chk("add_ready",   32'(result_ready), 32'd1);
    chk("add_result",  alu_result,        32'd12);
    chk("add_wr_addr", 32'(wr_addr),      32'd3);
    drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("add_pulse_end", 32'(result_ready), 32'd0);
    chk("add_hold",      alu_result,        32'd12);
    chk("add_hold_rd",   32'(wr_addr),      32'd3);

    // Back-to-back single-cycle ops
    drive(1'b1, C_SRA, 32'h8000_0000, 32'd4, 5'd10);
    @(negedge clk);
    chk("sra_ready", 32'(result_ready), 32'd1);
    chk("sra_result", alu_result, 32'hF800_0000);
    chk("sra_wr_addr", 32'(wr_addr), 32'd10);
    drive(1'b1, C_SLT, 32'hFFFF_FFFF, 32'd1, 5'd11);
    @(negedge clk);
    chk("slt_ready", 32'(result_ready), 32'd1);
    chk("slt_result", alu_result, 32'd1);
    chk("slt_wr_addr", 32'(wr_addr), 32'd11);
    drive(1'b1, C_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd12);
    @(negedge clk);
    chk("sltu_ready", 32'(result_ready), 32'd1);
    chk("sltu_result", alu_result, 32'd0);
    chk("sltu_wr_addr", 32'(wr_addr), 32'd12);
    drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("b2b_pulse_end", 32'(result_ready), 32'd0);

    // Randomized single-cycle traffic with idle gaps and unknown codes
    last_res = alu_result;
    last_rd  = wr_addr;
    for (int i = 0; i < 80; i++) begin
      r_op = 5'($urandom_range(0, 31));
`ifdef EXEC_MUL_EN
      if (r_op >= 5'd16 && r_op <= 5'd19) r_op = r_op - 5'd16;
`endif
      r_a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
      r_b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom();
      r_rd = 5'($urandom_range(0, 31));
      r_v  = ($urandom_range(0, 3) != 0);
      drive(r_v, r_op, r_a, r_b, r_rd);
      @(negedge clk);
      if (r_v) begin
        last_res = ref_result(r_op, r_a, r_b);
        last_rd  = r_rd;
      end
      chk($sformatf("rand%0d_op%0d_ready", i, r_op), 32'(result_ready), 32'(r_v));
      chk($sformatf("rand%0d_op%0d_result", i, r_op), alu_result, last_res);
      chk($sformatf("rand%0d_wr_addr", i), 32'(wr_addr), 32'(last_rd));
    end
    drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0);
    @(negedge clk);

`ifdef EXEC_MUL_EN
    // Directed multiplies
    run_mul("mul",    C_MUL,    32'hFFFF_FFFF, 32'd3, 5'd1);
    run_mul("mulh",   C_MULH,   32'hFFFF_FFFF, 32'd3, 5'd2);
    run_mul("mulhu",  C_MULHU,  32'hFFFF_FFFF, 32'd3, 5'd3);
    run_mul("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'd3, 5'd4);
    run_mul("mulh_min",   C_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5);
    run_mul("mulhsu_min", C_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    for (int i = 0; i < 6; i++) begin
      r_op = C_MUL + 5'($urandom_range(0, 3));
      run_mul($sformatf("rmul%0d_op%0d", i, r_op), r_op, $urandom(), $urandom(),
              5'($urandom_range(0, 31)));
    end

    // ADD held on op_valid while a multiply runs
    pulses = 0;
    drive(1'b1, C_MUL, 32'd7, 32'd9, 5'd4);
    @(negedge clk);
    drive(1'b1, C_ADD, 32'd100, 32'd23, 5'd6);
    for (int k = 2; k <= 45; k++) begin
      @(negedge clk);
      if (result_ready === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          chk("held_first_cycle", 32'(k), 32'd32);
          chk("held_first_result", alu_result, 32'd63);
          chk("held_first_rd", 32'(wr_addr), 32'd4);
        end else if (pulses == 2) begin
          chk("held_second_cycle", 32'(k), 32'd33);
          chk("held_second_result", alu_result, 32'd123);
          chk("held_second_rd", 32'(wr_addr), 32'd6);
          op_valid = 1'b0;
        end
      end else if (k < 32) begin
        chk("held_op_ready_low", 32'(op_ready), 32'd0);
      end
    end
    chk("held_pulse_count", 32'(pulses), 32'd2);

    // Reset asserted mid-multiply
    drive(1'b1, C_MUL, 32'h1234, 32'h5678, 5'd7);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) op_valid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midmul_reset");
    @(negedge clk);
    chk("midmul_reset_hold", 32'(result_ready), 32'd0);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk("midmul_op_ready", 32'(op_ready), 32'd1);
      if (result_ready === 1'b1) pulses++;
    end
    chk("midmul_no_pulse", 32'(pulses), 32'd0);
`else
    // Multiply codes behave as unknown single-cycle ops
    drive(1'b1, C_MUL, 32'd6, 32'd7, 5'd5);
    @(negedge clk);
    chk("nomul_ready",    32'(result_ready), 32'd1);
    chk("nomul_result",   alu_result,        32'd0);
    chk("nomul_wr_addr",  32'(wr_addr),      32'd5);
    chk("nomul_op_ready", 32'(op_ready),     32'd1);
    chk("nomul_busy",     32'(busy),         32'd0);
    drive(1'b1, C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    @(negedge clk);
    chk("nomul_mulhu_result", alu_result, 32'd0);
    chk("nomul_mulhu_op_ready", 32'(op_ready), 32'd1);
    drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("nomul_pulse_end", 32'(result_ready), 32'd0);

    // Reset after a result clears the registered outputs
    drive(1'b1, C_ADD, 32'd1, 32'd2, 5'd9);
    @(negedge clk);
    op_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk_reset_outputs("nomul_reset");
    @(negedge clk);
    reset_n = 1'b1;
`endif

    // Normal ADD after reset release
    @(negedge clk);
    drive(1'b1, C_ADD, 32'd20, 32'd22, 5'd11);
    @(negedge clk);
    chk("post_reset_ready",   32'(result_ready), 32'd1);
    chk("post_reset_result",  alu_result,        32'd42);
    chk("post_reset_wr_addr", 32'(wr_addr),      32'd11);
    drive(1'b0, C_ADD, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    chk("post_reset_pulse_end", 32'(result_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
